hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS32 core. It detects load-use hazards and taken-branch redirects, and waits on the data memory. It drives the stage write-enables and the ID_Control_NOP bubble input of the ID control decoder. It also holds the pipeline quiet after reset, traps data-memory timeouts, and keeps saturating stall/flush performance counters.

Parameters:
RESET_HOLD, 4, cycles after reset release during which the pipeline is frozen and bubbled (≥1)
MEM_TIMEOUT, 16, consecutive DMem_Ready-low cycles that trigger the ERROR state (≥2)
CNT_W, 16, width of the performance counters

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
Opcode_ID  in  6  opcode field of the instruction in ID
Rs_ID  in  5  rs field of the instruction in ID
Rt_ID  in  5  rt field of the instruction in ID
MemRead_EX  in  1  instruction in EX is a load
Rt_EX  in  5  destination rt of the instruction in EX
MemAccess_MEM  in  1  instruction in MEM reads or writes data memory
DMem_Ready  in  1  data memory completes the access this cycle
Branch_Taken_MEM  in  1  BEQ in MEM resolved taken
PCWrite  out  1  PC register load enable
IFID_Write  out  1  IF/ID register load enable
IFID_Flush  out  1  clear IF/ID to NOP
ID_Control_NOP  out  1  force NOP control word out of ID (bubble into ID/EX)
EXMEM_Flush  out  1  clear EX/MEM control bits
Pipe_Freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
Mem_Error  out  1  sticky data-memory timeout flag
Stall_Count  out  CNT_W  saturating stall-cycle count
Flush_Count  out  CNT_W  saturating taken-branch count

Behaviour:
- States: INIT, RUN, MEM_WAIT, ERROR. Reset (async) → INIT, hold counter=0, wait_cnt=0, Stall_Count=0, Flush_Count=0, Mem_Error=0.
- Outputs in reset/INIT: PCWrite=0, IFID_Write=0, IFID_Flush=1, ID_Control_NOP=1, EXMEM_Flush=1, Pipe_Freeze=0 (bubbles propagate).
- INIT: hold counter increments each cycle; after RESET_HOLD cycles in INIT → RUN. Reset mid-operation from any state returns to INIT immediately.
- Control outputs are combinational from state and inputs (same-cycle effect). Counters, wait_cnt and state are registered. Default in RUN: PCWrite=1, IFID_Write=1, all other controls 0.
- Priority in RUN/MEM_WAIT, highest first:
  1. mem_stall = MemAccess_MEM & ~DMem_Ready → Pipe_Freeze=1, PCWrite=0, IFID_Write=0, ID_Control_NOP=0, no flushes. A coincident Branch_Taken_MEM is ignored; it is held by the freeze and acted on once ready.
  2. Branch_Taken_MEM → PCWrite=1 (loads target), IFID_Flush=1, ID_Control_NOP=1, EXMEM_Flush=1.
  3. load_use → PCWrite=0, IFID_Write=0, ID_Control_NOP=1. Exactly one bubble; the next cycle has no hazard because the load is in MEM.
- load_use = MemRead_EX & (Rt_EX≠0) & ((Rt_EX==Rs_ID) | (Rt_EX==Rt_ID & uses_rt)). uses_rt is true for opcodes 000000, 101011 and 000100. Opcode 100000 (NOP) never raises load_use.
- RUN → MEM_WAIT on mem_stall, with wait_cnt=1. In MEM_WAIT:
  - DMem_Ready=1 → RUN, wait_cnt=0.
  - Otherwise wait_cnt increments; when a not-ready cycle occurs with wait_cnt==MEM_TIMEOUT-1 → ERROR.
- ERROR: Mem_Error=1, Pipe_Freeze=1, PCWrite=0, IFID_Write=0, flushes 0. Exit only via Reset.
- Stall_Count +1 on every RUN/MEM_WAIT cycle with mem_stall or load_use. Not counted in INIT/ERROR.
- Flush_Count +1 on every acted-upon taken branch.
- Both counters saturate at 2^CNT_W−1 and never wrap.

Test Plan:
- Reset release with RESET_HOLD=4 → ID_Control_NOP=1, PCWrite=0 for exactly 4 cycles; cycle 5: PCWrite=1, IFID_Write=1, ID_Control_NOP=0.
- Load-use: MemRead_EX=1, Rt_EX=8; ID holds R-type with Rs_ID=8 → one cycle PCWrite=0, IFID_Write=0, ID_Control_NOP=1, Stall_Count=1. With Rt_EX=0, or Rt_ID=8 and Opcode_ID=100011 → no stall.
- Taken branch coincident with load-use → PCWrite=1, IFID_Flush=1, ID_Control_NOP=1, EXMEM_Flush=1; Flush_Count=1, Stall_Count unchanged.
- MemAccess_MEM=1, DMem_Ready low 3 cycles, then high → Pipe_Freeze=1 for 3 cycles, Stall_Count=3, back to RUN, Mem_Error=0.
- DMem_Ready low 16 consecutive cycles (MEM_TIMEOUT=16) → Mem_Error=1 and frozen from cycle 17. Ready=1 afterwards does not unfreeze; Reset pulse clears all and re-enters INIT.
- CNT_W=4, 20 load-use stalls → Stall_Count holds 15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS32 core: load-use bubbles,
// taken-branch flushes, data-memory waits/timeouts, post-reset quiet period, perf counters.
module hazard_stall_controller #(
  parameter int RESET_HOLD  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Opcode_ID,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rt_EX,
  input  logic             MemAccess_MEM,
  input  logic             DMem_Ready,
  input  logic             Branch_Taken_MEM,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             ID_Control_NOP,
  output logic             EXMEM_Flush,
  output logic             Pipe_Freeze,
  output logic             Mem_Error,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam int HOLD_W = (RESET_HOLD  < 2) ? 1 : $clog2(RESET_HOLD + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [CNT_W-1:0]   flush_cnt_reg;
  logic               mem_error_reg;

  logic uses_rt;
  logic load_use;
  logic mem_stall;
  logic active;
  logic stall_event;
  logic flush_event;

  always_comb begin
    uses_rt   = (Opcode_ID == OP_RTYPE) || (Opcode_ID == OP_SW) || (Opcode_ID == OP_BEQ);
    load_use  = MemRead_EX && (Rt_EX != 5'd0) && (Opcode_ID != OP_NOP) &&
                ((Rt_EX == Rs_ID) || ((Rt_EX == Rt_ID) && uses_rt));
    mem_stall = MemAccess_MEM && !DMem_Ready;
    active    = (state_reg == RUN) || (state_reg == MEM_WAIT);
    // A branch coincident with a memory stall is frozen in MEM and counted once it proceeds.
    stall_event = active && (mem_stall || (load_use && !Branch_Taken_MEM));
    flush_event = active && !mem_stall && Branch_Taken_MEM;
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      INIT: begin
        wait_cnt_next = '0;
        if (hold_cnt_reg == HOLD_W'(RESET_HOLD - 1)) begin
          state_next = RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      RUN: begin
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_next = ERROR;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      default: begin
        state_next = ERROR;
      end
    endcase
  end

  always_comb begin
    PCWrite        = 1'b0;
    IFID_Write     = 1'b0;
    IFID_Flush     = 1'b0;
    ID_Control_NOP = 1'b0;
    EXMEM_Flush    = 1'b0;
    Pipe_Freeze    = 1'b0;
    case (state_reg)
      INIT: begin
        // Let bubbles drain through the back end while fetch stays parked.
        IFID_Flush     = 1'b1;
        ID_Control_NOP = 1'b1;
        EXMEM_Flush    = 1'b1;
      end
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          Pipe_Freeze = 1'b1;
        end else if (Branch_Taken_MEM) begin
          PCWrite        = 1'b1;
          IFID_Write     = 1'b1;
          IFID_Flush     = 1'b1;
          ID_Control_NOP = 1'b1;
          EXMEM_Flush    = 1'b1;
        end else if (load_use) begin
          ID_Control_NOP = 1'b1;
        end else begin
          PCWrite    = 1'b1;
          IFID_Write = 1'b1;
        end
      end
      default: begin
        Pipe_Freeze = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= INIT;
      hold_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
      mem_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_next == ERROR) begin
        mem_error_reg <= 1'b1;
      end
      if (stall_event && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (flush_event && (flush_cnt_reg != {CNT_W{1'b1}})) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign Mem_Error   = mem_error_reg;
  assign Stall_Count = stall_cnt_reg;
  assign Flush_Count = flush_cnt_reg;

endmodule
